// File: rtl/systolic_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_mem_responder_if
// Description : Host stream ports and controller memory bus for the systolic
//               memory responder.
//               master : host + systolic controller side
//               slave  : responder side
//   in_valid/in_data/in_ready     host -> responder word stream (A then B)
//   out_valid/out_data/out_ready  responder -> host word stream (C)
//   act_addr/mem_write/
//   mem_data_write/mem_read       controller RAM access, 1-cycle read
//   new_data                      one-cycle launch pulse to the controller
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_mem_responder_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 12
);
   logic              in_valid;
   logic [WIDTH-1:0]  in_data;
   logic              in_ready;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic              out_ready;
   logic [ADDR_W-1:0] act_addr;
   logic              mem_write;
   logic [WIDTH-1:0]  mem_data_write;
   logic [WIDTH-1:0]  mem_read;
   logic              new_data;

   modport master (
      output in_valid, in_data, out_ready, act_addr, mem_write, mem_data_write,
      input  in_ready, out_valid, out_data, mem_read, new_data
   );

   modport slave (
      input  in_valid, in_data, out_ready, act_addr, mem_write, mem_data_write,
      output in_ready, out_valid, out_data, mem_read, new_data
   );
endinterface
`default_nettype wire

// File: rtl/systolic_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_mem_responder
// Description : Scratch-RAM owner for the systolic array controller. Loads A
//               and B from the host, launches the controller, serves its
//               reads/writes, then streams C back to the host.
// Ports       :
//   clk, rst            clock, synchronous active-high reset
//   start               job request (IDLE only)
//   addr_A/B/C, n       job configuration, captured at accepted start
//   bus (slave)         host in/out streams and controller memory bus
//   busy                high outside IDLE
//   done                pulse on the final C transfer
//   cfg_err             pulse when start is rejected for a bad n
//   wr_err              sticky flag for dropped controller writes
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_mem_responder #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 12,
   parameter int N      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      addr_A,
   input  logic [ADDR_W-1:0]      addr_B,
   input  logic [ADDR_W-1:0]      addr_C,
   input  logic [3:0]             n,
   systolic_mem_responder_if.slave bus,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err,
   output logic                   wr_err
);

   localparam int              c_DEPTH = 2 ** ADDR_W;
   localparam int              c_KW    = $clog2(N * N + 1);
   localparam logic [4:0]      c_NMAX  = 5'(N);
   localparam logic [c_KW-1:0] c_KONE  = 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_A  = 3'd1,
      S_LOAD_B  = 3'd2,
      S_KICK    = 3'd3,
      S_COMPUTE = 3'd4,
      S_DUMP    = 3'd5
   } state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_base_a, r_base_b, r_base_c;
   logic [c_KW-1:0]   r_k, r_idx, r_wcnt, r_ptr;
   logic [WIDTH-1:0]  r_mem [0:c_DEPTH-1];

   logic [7:0]        w_nsq;
   logic              w_n_ok, w_start_ok, w_wr_bad, w_we;
   logic              w_idx_last, w_wcnt_last, w_dump_last, w_in_win, w_out_xfer;
   logic [ADDR_W-1:0] w_c_off, w_dump_addr, w_waddr;
   logic [WIDTH-1:0]  w_wdata;

   // Helper decodes shared by the FSM and the datapath
   always_comb begin
      w_nsq       = {4'b0, n} * {4'b0, n};
      w_n_ok      = (n != 4'd0) && ({1'b0, n} <= c_NMAX);
      // Offset into the C window; unsigned wrap makes "below base" look huge
      w_c_off     = bus.act_addr - r_base_c;
      w_in_win    = w_c_off < ADDR_W'(r_k);
      w_idx_last  = (r_idx + c_KONE) == r_k;
      w_wcnt_last = (r_wcnt + c_KONE) == r_k;
      // r_ptr counts words already loaded into the output register
      w_dump_last = r_ptr == r_k;
      w_dump_addr = r_base_c + ADDR_W'(r_ptr);
      w_out_xfer  = bus.out_valid && bus.out_ready;
   end

   // Next-state and control outputs
   always_comb begin
      w_next       = r_state;
      bus.in_ready = 1'b0;
      bus.new_data = 1'b0;
      busy         = (r_state != S_IDLE);
      done         = 1'b0;
      cfg_err      = 1'b0;
      w_start_ok   = 1'b0;
      w_wr_bad     = bus.mem_write;
      w_we         = 1'b0;
      w_waddr      = bus.act_addr;
      w_wdata      = bus.mem_data_write;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_n_ok) begin
                  w_start_ok = 1'b1;
                  w_next     = S_LOAD_A;
               end else begin
                  cfg_err = 1'b1;
               end
            end
         end
         S_LOAD_A: begin
            bus.in_ready = 1'b1;
            w_waddr      = r_base_a + ADDR_W'(r_idx);
            w_wdata      = bus.in_data;
            if (bus.in_valid) begin
               w_we = 1'b1;
               if (w_idx_last) w_next = S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            bus.in_ready = 1'b1;
            w_waddr      = r_base_b + ADDR_W'(r_idx);
            w_wdata      = bus.in_data;
            if (bus.in_valid) begin
               w_we = 1'b1;
               if (w_idx_last) w_next = S_KICK;
            end
         end
         S_KICK: begin
            bus.new_data = 1'b1;
            w_next       = S_COMPUTE;
         end
         S_COMPUTE: begin
            w_wr_bad = bus.mem_write && !w_in_win;
            if (bus.mem_write && w_in_win) begin
               w_we = 1'b1;
               if (w_wcnt_last) w_next = S_DUMP;
            end
         end
         S_DUMP: begin
            if (w_out_xfer && w_dump_last) begin
               done   = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase

      // Never let a reset cycle disturb RAM contents
      if (rst) w_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_base_a      <= '0;
         r_base_b      <= '0;
         r_base_c      <= '0;
         r_k           <= '0;
         r_idx         <= '0;
         r_wcnt        <= '0;
         r_ptr         <= '0;
         wr_err        <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else begin
         // An accepted start re-arms the error flag before anything new can set it
         if (w_start_ok) begin
            r_base_a <= addr_A;
            r_base_b <= addr_B;
            r_base_c <= addr_C;
            r_k      <= c_KW'(w_nsq);
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_ptr    <= '0;
            wr_err   <= 1'b0;
         end else if (w_wr_bad) begin
            wr_err <= 1'b1;
         end

         if ((r_state == S_LOAD_A || r_state == S_LOAD_B) && bus.in_valid)
            r_idx <= w_idx_last ? '0 : r_idx + c_KONE;

         if (r_state == S_COMPUTE && w_we)
            r_wcnt <= r_wcnt + c_KONE;

         // Output register is filled on DUMP entry and refilled on every
         // transfer, so words flow back-to-back and hold while stalled.
         if (r_state == S_DUMP) begin
            if (!bus.out_valid || (bus.out_ready && !w_dump_last)) begin
               bus.out_data  <= r_mem[w_dump_addr];
               bus.out_valid <= 1'b1;
               r_ptr         <= r_ptr + c_KONE;
            end else if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
            end
         end
      end
   end

   // Single write port; host loads and controller writes are state-exclusive
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   // Controller read port: registered, read-before-write on collisions
   always_ff @(posedge clk) begin
      if (rst) bus.mem_read <= '0;
      else     bus.mem_read <= r_mem[bus.act_addr];
   end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_mem_responder
// Description : Randomized self-checking bench for systolic_mem_responder
//               against a word-level RAM/job model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] addr_A, addr_B, addr_C;
   logic [3:0]  n_dim;
   logic        busy, done, cfg_err, wr_err;

   systolic_mem_responder_if #(.WIDTH(16), .ADDR_W(12)) bus ();

   systolic_mem_responder #(.WIDTH(16), .ADDR_W(12), .N(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .addr_A  (addr_A),
      .addr_B  (addr_B),
      .addr_C  (addr_C),
      .n       (n_dim),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .cfg_err (cfg_err),
      .wr_err  (wr_err)
   );

   always #5 clk = ~clk;

   // Reference model: word-addressed RAM image plus the sticky error flag
   logic [15:0] m_ram   [0:4095];
   bit          m_known [0:4095];
   logic        m_wr_err;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          kind;   // 0 read, 1 legal write, 2 illegal write, 3 read + bad start
      logic [11:0] addr;
      logic [15:0] data;
   } op_t;
   op_t ops[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void push_op(input int kind, input logic [11:0] addr, input logic [15:0] data);
      op_t o;
      o.kind = kind;
      o.addr = addr;
      o.data = data;
      ops.push_back(o);
   endfunction

   task automatic check_zero(input string tag);
      check_eq({tag, "_busy"},      busy, 0);
      check_eq({tag, "_done"},      done, 0);
      check_eq({tag, "_cfg_err"},   cfg_err, 0);
      check_eq({tag, "_wr_err"},    wr_err, 0);
      check_eq({tag, "_in_ready"},  bus.in_ready, 0);
      check_eq({tag, "_out_valid"}, bus.out_valid, 0);
      check_eq({tag, "_out_data"},  bus.out_data, 0);
      check_eq({tag, "_new_data"},  bus.new_data, 0);
      check_eq({tag, "_mem_read"},  bus.mem_read, 0);
   endtask

   task automatic read_check(input string tag, input logic [11:0] a);
      bus.act_addr = a;
      @(posedge clk);
      @(negedge clk);
      if (m_known[a]) check_eq(tag, bus.mem_read, m_ram[a]);
      @(posedge clk); #1;
   endtask

   task automatic bad_cfg(input logic [3:0] nbad);
      start = 1'b1;
      n_dim = nbad;
      @(negedge clk);
      check_eq("bad_cfg_err", cfg_err, 1);
      check_eq("bad_busy", busy, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("bad_stay_idle", busy, 0);
      check_eq("bad_in_ready", bus.in_ready, 0);
      check_eq("bad_cfg_err_low", cfg_err, 0);
      check_eq("bad_wr_err_kept", wr_err, m_wr_err);
      @(posedge clk); #1;
   endtask

   task automatic run_job(input logic [11:0] aA, input logic [11:0] aB, input logic [11:0] aC,
                          input int nn, input int rmode, input bit directed);
      int          K, cyc, loaded, got, j;
      bit          seen, r, have_prev, prev_known, cur_known;
      logic [15:0] w, prev_exp, cur_exp;
      logic [11:0] a;
      logic [15:0] expq[$];
      int          perm[16];
      logic [15:0] rdlat[3];
      bit          pat[4];
      rdlat[0] = 16'd1; rdlat[1] = 16'd2; rdlat[2] = 16'd2;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      K = nn * nn;

      start = 1'b1; addr_A = aA; addr_B = aB; addr_C = aC; n_dim = 4'(nn);
      @(negedge clk);
      check_eq("start_cfg_err", cfg_err, 0);
      check_eq("start_busy", busy, 0);
      @(posedge clk); #1;
      start = 1'b0;
      m_wr_err = 1'b0;

      // Load A then B
      loaded = 0; cyc = 0;
      while (loaded < 2 * K && cyc < 2000) begin
         bus.in_valid = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
         w = directed ? ((loaded < K) ? 16'(loaded + 1) : 16'(2 * (loaded - K + 1)))
                      : 16'($urandom);
         bus.in_data = w;
         @(negedge clk);
         check_eq("load_in_ready", bus.in_ready, 1);
         check_eq("load_busy", busy, 1);
         check_eq("load_new_data", bus.new_data, 0);
         check_eq("load_wr_err", wr_err, m_wr_err);
         if (bus.in_valid) begin
            a = (loaded < K) ? aA + 12'(loaded) : aB + 12'(loaded - K);
            m_ram[a] = w; m_known[a] = 1'b1;
            loaded++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      if (loaded < 2 * K) check_eq("load_timeout", loaded, 2 * K);

      @(negedge clk);
      check_eq("kick_new_data", bus.new_data, 1);
      check_eq("kick_in_ready", bus.in_ready, 0);
      check_eq("kick_busy", busy, 1);
      @(posedge clk); #1;

      // Controller traffic plan
      ops.delete();
      if (directed) begin
         push_op(0, 12'd16, 16'd0);
         push_op(0, 12'd17, 16'd0);
         push_op(0, 12'd32, 16'd0);
         for (int i = 0; i < 15; i++) push_op(1, aC + 12'(i), 16'(180 + 20 * i));
         push_op(2, 12'd70, 16'hBEEF);
         push_op(3, aA, 16'd0);
         push_op(1, aC + 12'd15, 16'(180 + 20 * 15));
      end else begin
         for (int i = 0; i < K; i++) perm[i] = i;
         for (int i = K - 1; i > 0; i--) begin
            int jj, t;
            jj = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[jj]; perm[jj] = t;
         end
         for (int i = 0; i < K; i++) begin
            repeat ($urandom_range(0, 2)) begin
               case ($urandom_range(0, 2))
                  0:       push_op(0, aA + 12'($urandom_range(0, K - 1)), 16'd0);
                  1:       push_op(0, aB + 12'($urandom_range(0, K - 1)), 16'd0);
                  default: push_op(0, aC + 12'($urandom_range(0, K - 1)), 16'd0);
               endcase
            end
            push_op(1, aC + 12'(perm[i]), 16'($urandom));
         end
      end

      have_prev = 1'b0; prev_known = 1'b0; prev_exp = '0;
      j = 0;
      foreach (ops[k]) begin
         bus.act_addr       = ops[k].addr;
         bus.mem_write      = (ops[k].kind == 1 || ops[k].kind == 2);
         bus.mem_data_write = ops[k].data;
         start              = (ops[k].kind == 3);
         n_dim              = 4'd0;
         cur_exp   = m_ram[ops[k].addr];
         cur_known = m_known[ops[k].addr];
         @(negedge clk);
         if (have_prev && prev_known) check_eq("cmp_mem_read", bus.mem_read, prev_exp);
         if (directed && j >= 1 && j <= 3) check_eq("rdlat", bus.mem_read, rdlat[j - 1]);
         check_eq("cmp_out_valid", bus.out_valid, 0);
         check_eq("cmp_busy", busy, 1);
         check_eq("cmp_in_ready", bus.in_ready, 0);
         check_eq("cmp_cfg_err", cfg_err, 0);
         check_eq("cmp_wr_err", wr_err, m_wr_err);
         if (ops[k].kind == 1) begin
            m_ram[ops[k].addr] = ops[k].data; m_known[ops[k].addr] = 1'b1;
         end
         if (ops[k].kind == 2) m_wr_err = 1'b1;
         prev_exp = cur_exp; prev_known = cur_known; have_prev = 1'b1;
         @(posedge clk); #1;
         j++;
      end
      bus.mem_write = 1'b0;
      start = 1'b0;

      for (int i = 0; i < K; i++) expq.push_back(m_ram[aC + 12'(i)]);

      // Drain C
      got = 0; cyc = 0; seen = 1'b0;
      while (got < K && cyc < 400) begin
         case (rmode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: r = pat[cyc % 4];
         endcase
         bus.out_ready = r;
         bus.act_addr  = aA + 12'($urandom_range(0, K - 1));
         cur_exp   = m_ram[bus.act_addr];
         cur_known = m_known[bus.act_addr];
         @(negedge clk);
         if (have_prev && prev_known) check_eq("dump_mem_read", bus.mem_read, prev_exp);
         check_eq("dump_busy", busy, 1);
         if (bus.out_valid) begin
            if (!seen) begin
               seen = 1'b1;
               check_eq("dump_first_latency", (cyc <= 2), 1);
            end
            check_eq("dump_data", bus.out_data, expq[got]);
            check_eq("dump_done", done, (r && got == K - 1));
            if (r) got++;
         end else begin
            check_eq("dump_done_idle", done, 0);
         end
         prev_exp = cur_exp; prev_known = cur_known;
         @(posedge clk); #1;
         cyc++;
      end
      bus.out_ready = 1'b0;
      if (got < K) check_eq("dump_timeout", got, K);
      @(negedge clk);
      check_eq("post_busy", busy, 0);
      check_eq("post_out_valid", bus.out_valid, 0);
      check_eq("post_done", done, 0);
      @(posedge clk); #1;
   endtask

   task automatic reset_mid_job();
      logic [11:0] a;
      start = 1'b1; addr_A = 12'd16; addr_B = 12'd32; addr_C = 12'd48; n_dim = 4'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 21; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'(300 + i);
         @(negedge clk);
         check_eq("rmj_in_ready", bus.in_ready, 1);
         check_eq("rmj_done", done, 0);
         a = (i < 16) ? 12'(16 + i) : 12'(32 + i - 16);
         m_ram[a] = 16'(300 + i); m_known[a] = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_zero("rmj");
      @(posedge clk); #1;
      rst = 1'b0;
      m_wr_err = 1'b0;
      @(negedge clk);
      check_eq("rmj_idle_busy", busy, 0);
      @(posedge clk); #1;
      for (int i = 16; i < 32; i++) read_check("rmj_ram_A", 12'(i));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         m_known[i] = 1'b0;
         m_ram[i]   = '0;
      end
      m_wr_err = 1'b0;
      rst = 1'b1; start = 1'b0;
      addr_A = '0; addr_B = '0; addr_C = '0; n_dim = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      bus.act_addr = '0; bus.mem_write = 1'b0; bus.mem_data_write = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      bad_cfg(4'd0);
      bad_cfg(4'd5);

      // Seed a known region around address 70
      run_job(12'd64, 12'($urandom_range(200, 3000)), 12'($urandom_range(200, 3000)), 4, 1, 1'b0);
      run_job(12'd16, 12'd32, 12'd48, 4, 0, 1'b1);
      read_check("ram70", 12'd70);
      check_eq("wr_err_sticky", wr_err, 1);
      bad_cfg(4'd5);

      run_job(12'($urandom), 12'($urandom), 12'($urandom), 4, 2, 1'b0);
      run_job(12'hFFA, 12'h005, 12'hFFE, 4, 1, 1'b0);
      run_job(12'd100, 12'd104, 12'd98, 3, 2, 1'b0);
      for (int t = 0; t < 6; t++)
         run_job(12'($urandom), 12'($urandom), 12'($urandom), $urandom_range(1, 4),
                 $urandom_range(0, 2), 1'b0);

      reset_mid_job();
      run_job(12'($urandom), 12'($urandom), 12'($urandom), $urandom_range(1, 4), 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/systolic_mem_responder.md
Name: systolic_mem_responder

Overview:
- Memory-side responder for the systolic array controller; owns the scratch RAM the controller reads A/B from and writes C to.
- Host side: streams matrices A and B in over a valid/ready port, then pulses new_data to launch the controller.
- Controller side: serves act_addr reads with 1-cycle latency and counts C writebacks.
- After all C writebacks, streams C back to the host over a valid/ready output port.

Parameters:
- WIDTH, 16, data word width (signed).
- ADDR_W, 12, address width; RAM depth is 2**ADDR_W words.
- N, 4, maximum matrix dimension accepted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  host request to begin a load/compute/dump job; sampled only in IDLE.
- addr_A  in  ADDR_W  base address of A; sampled at accepted start.
- addr_B  in  ADDR_W  base address of B; sampled at accepted start.
- addr_C  in  ADDR_W  base address of C; sampled at accepted start.
- n  in  4  matrix dimension; sampled at accepted start.
- in_valid  in  1  host input word valid.
- in_data  in  WIDTH  host input word (A row-major, then B row-major).
- in_ready  out  1  responder accepts in_data.
- out_valid  out  1  C word valid.
- out_data  out  WIDTH  C word (row-major).
- out_ready  in  1  host accepts out_data.
- act_addr  in  ADDR_W  controller memory address.
- mem_write  in  1  controller write strobe.
- mem_data_write  in  WIDTH  controller write data.
- mem_read  out  WIDTH  read data for act_addr, registered.
- new_data  out  1  one-cycle launch pulse to controller.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last C word is accepted.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- wr_err  out  1  sticky; set by an illegal controller write; cleared by rst or by accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. RAM contents are not cleared by rst.
- Reset mid-job: the next edge returns to IDLE with no done pulse.
- Configuration:
  - Let K = n*n.
  - Start is accepted only in IDLE with 1<=n<=N.
  - Otherwise start is ignored, cfg_err pulses one cycle, and state stays IDLE.
- Addresses are base + offset, mod 2**ADDR_W (wrap permitted).
- mem_read path:
  - Every cycle, in every state, mem_read <= RAM[act_addr].
  - Read latency is 1 cycle.
  - A same-cycle write and read to the same address returns the old data.
- States:
  - IDLE --accepted start--> LOAD_A.
  - LOAD_A:
    - in_ready=1.
    - Each in_valid&&in_ready writes in_data to addr_A+idx; idx increments.
    - After the K-th word: idx=0, go to LOAD_B.
  - LOAD_B:
    - Same as LOAD_A, writing to addr_B+idx.
    - After the K-th word: go to KICK.
  - KICK: new_data=1 for exactly this one cycle; go to COMPUTE.
  - COMPUTE:
    - in_ready=0.
    - A mem_write with act_addr-addr_C (mod 2**ADDR_W) < K writes RAM and increments wcnt.
    - A mem_write outside that window is dropped and sets wr_err.
    - When wcnt reaches K: go to DUMP.
  - DUMP:
    - Streams RAM[addr_C+0..K-1] in order.
    - Prefetches so that out_valid rises at most 2 cycles after DUMP entry.
    - out_data is stable while out_valid&&!out_ready.
    - A new word is presented in the cycle after each transfer (back-to-back at full rate when out_ready stays high).
    - After the K-th transfer: done pulses in that cycle, out_valid=0, go to IDLE.
- Controller writes outside COMPUTE are dropped and set wr_err. Host port writes never occur outside LOAD_A and LOAD_B.
- in_ready=0 in all states except LOAD_A and LOAD_B.
- start asserted while busy is ignored; no cfg_err.
- Overlapping A/B/C regions are legal; later writes win.
- Data is passed through unmodified; no arithmetic on data words.

Test Plan:
- Load/kick:
  - Setup: addr_A=16, addr_B=32, addr_C=48, n=4; stream A=1..16 then B=2,4..32 with in_valid held high.
  - Required: in_ready drops after 32 words; new_data is high for exactly 1 cycle; busy=1 throughout.
- Read latency:
  - Stimulus: in COMPUTE, drive act_addr=16,17,32 on consecutive cycles.
  - Required: mem_read = 1, 2, 2 on the following cycles.
- Writeback and dump:
  - Stimulus: 16 mem_writes to 48..63 with data 180,200,220,240,…; hold out_ready=1.
  - Required: DUMP emits the same 16 values in order; done pulses on the 16th transfer; busy=0 next cycle.
- Backpressure:
  - Stimulus: out_ready toggles 1-0-0-1.
  - Required: out_data holds its value across the stalled cycles; no word is lost or duplicated.
- Error cases:
  - n=0 start → cfg_err pulse; state stays IDLE.
  - n=5 start → cfg_err pulse; state stays IDLE.
  - mem_write to 70 in COMPUTE → wr_err=1; RAM[70] unchanged; wcnt unchanged.
  - Next accepted start → wr_err=0.
- Reset mid-job:
  - Stimulus: rst=1 during LOAD_B after 5 words.
  - Required: all outputs 0; state IDLE; RAM[16..31] still holds A values.
